// File: rtl/sorter_pkg.sv
// Shared types and helpers for the compare-exchange sorter cells.
package sorter_pkg;

    localparam int unsigned SORT_WIDTH_DEFAULT = 4;
    localparam int unsigned SORT_WIDTH_MAX     = 32;

    typedef logic [SORT_WIDTH_DEFAULT-1:0] sort_word_t;

    // Unsigned magnitude compare; callers zero-extend narrower words.
    function automatic logic cmp_gt(input logic [SORT_WIDTH_MAX-1:0] a,
                                    input logic [SORT_WIDTH_MAX-1:0] b);
        return a > b;
    endfunction

endpackage

// File: rtl/sorter_cmp_swap.sv
// Combinational compare-exchange: lo_c/hi_c hold the ordered pair, swap_c flags an exchange.
// Ties keep the operand order (lo_c = a, hi_c = b).
module sorter_cmp_swap
    import sorter_pkg::*;
#(
    parameter int unsigned WIDTH = SORT_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo_c,
    output logic [WIDTH-1:0] hi_c,
    output logic             swap_c
);

    always_comb begin
        swap_c = cmp_gt(SORT_WIDTH_MAX'(a), SORT_WIDTH_MAX'(b));
        lo_c   = swap_c ? b : a;
        hi_c   = swap_c ? a : b;
    end

endmodule

// File: rtl/bottom_sorter2.sv
// Registered two-input compare-exchange stage, last cell of the sorter chain.
// Optional BOTTOM_SORTER_SWAP_FLAG_EN adds the registered 'swapped' output.
module bottom_sorter2
    import sorter_pkg::*;
#(
    parameter int unsigned WIDTH      = SORT_WIDTH_DEFAULT,
    parameter bit          DESCENDING = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
`ifdef BOTTOM_SORTER_SWAP_FLAG_EN
    output logic             swapped,
`endif
    output logic [WIDTH-1:0] o1,
    output logic [WIDTH-1:0] o2
);

    logic [WIDTH-1:0] a_c;
    logic [WIDTH-1:0] b_c;
    logic [WIDTH-1:0] lo_c;
    logic [WIDTH-1:0] hi_c;
    logic             swap_c;
    logic [WIDTH-1:0] o1_nxt_c;
    logic [WIDTH-1:0] o2_nxt_c;

    // Descending mode feeds the operands reversed so the cell's swap bit and
    // tie behaviour (i1 stays in o1) carry over unchanged.
    always_comb begin
        a_c = DESCENDING ? i2 : i1;
        b_c = DESCENDING ? i1 : i2;
    end

    sorter_cmp_swap #(
        .WIDTH (WIDTH)
    ) u_cmp_swap (
        .a      (a_c),
        .b      (b_c),
        .lo_c   (lo_c),
        .hi_c   (hi_c),
        .swap_c (swap_c)
    );

    always_comb begin
        o1_nxt_c = DESCENDING ? hi_c : lo_c;
        o2_nxt_c = DESCENDING ? lo_c : hi_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o1 <= '0;
            o2 <= '0;
        end else begin
            o1 <= o1_nxt_c;
            o2 <= o2_nxt_c;
        end
    end

`ifdef BOTTOM_SORTER_SWAP_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swapped <= 1'b0;
        end else begin
            swapped <= swap_c;
        end
    end
`else
    logic unused_swap_c;
    assign unused_swap_c = swap_c;
`endif

endmodule

// File: tb/tb_bottom_sorter2.sv
// Bench for bottom_sorter2: ascending and descending instances share stimulus;
// expectations come from a min/max reference model.
module tb_bottom_sorter2;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] i1 = '0;
    logic [W-1:0] i2 = '0;
    logic [W-1:0] o1a, o2a, o1d, o2d;
`ifdef BOTTOM_SORTER_SWAP_FLAG_EN
    logic         swa, swd;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bottom_sorter2 #(.WIDTH(W), .DESCENDING(1'b0)) u_asc (
        .clk     (clk),
        .rst_n   (rst_n),
        .i1      (i1),
        .i2      (i2),
`ifdef BOTTOM_SORTER_SWAP_FLAG_EN
        .swapped (swa),
`endif
        .o1      (o1a),
        .o2      (o2a)
    );

    bottom_sorter2 #(.WIDTH(W), .DESCENDING(1'b1)) u_dsc (
        .clk     (clk),
        .rst_n   (rst_n),
        .i1      (i1),
        .i2      (i2),
`ifdef BOTTOM_SORTER_SWAP_FLAG_EN
        .swapped (swd),
`endif
        .o1      (o1d),
        .o2      (o2d)
    );

    // Reference model: a sorted pair is just (min, max) or (max, min).
    function automatic logic [W-1:0] ref_min(input logic [W-1:0] a, input logic [W-1:0] b);
        int ia, ib;
        ia = int'(a);
        ib = int'(b);
        return (ia < ib) ? a : b;
    endfunction

    function automatic logic [W-1:0] ref_max(input logic [W-1:0] a, input logic [W-1:0] b);
        int ia, ib;
        ia = int'(a);
        ib = int'(b);
        return (ia > ib) ? a : b;
    endfunction

    // Present a pair between edges, then step past the capturing edge.
    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        i1 = a;
        i2 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i1 = 4'd2;
        i2 = 4'd1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({o1a, o2a, o1d, o2d} !== '0) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d got asc=(%0d,%0d) dsc=(%0d,%0d) want all 0",
                         k, o1a, o2a, o1d, o2d);
            end
`ifdef BOTTOM_SORTER_SWAP_FLAG_EN
            checks++;
            if ({swa, swd} !== 2'b00) begin
                errors++;
                $display("FAIL reset_swapped cyc%0d got %b%b want 00", k, swa, swd);
            end
`endif
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_pairs(input string name, input logic [W-1:0] av[$], input logic [W-1:0] bv[$]);
        for (int k = 0; k < av.size(); k++) begin
            drive(av[k], bv[k]);
            checks++;
            if ({o1a, o2a, o1d, o2d} !== {ref_min(av[k], bv[k]), ref_max(av[k], bv[k]),
                                          ref_max(av[k], bv[k]), ref_min(av[k], bv[k])}) begin
                errors++;
                $display("FAIL %s_pair in=(%0d,%0d) got asc=(%0d,%0d) dsc=(%0d,%0d) want asc=(%0d,%0d) dsc=(%0d,%0d)",
                         name, av[k], bv[k], o1a, o2a, o1d, o2d,
                         ref_min(av[k], bv[k]), ref_max(av[k], bv[k]),
                         ref_max(av[k], bv[k]), ref_min(av[k], bv[k]));
            end
`ifdef BOTTOM_SORTER_SWAP_FLAG_EN
            checks++;
            if ({swa, swd} !== {av[k] > bv[k], bv[k] > av[k]}) begin
                errors++;
                $display("FAIL %s_swapped in=(%0d,%0d) got %b%b want %b%b", name, av[k], bv[k],
                         swa, swd, av[k] > bv[k], bv[k] > av[k]);
            end
`endif
        end
    endtask

    task automatic test_basic();
        test_pairs("basic", '{4'd2, 4'd3}, '{4'd1, 4'd9});
    endtask

    task automatic test_ties_extremes();
        test_pairs("tie_ext", '{4'd7, 4'd15, 4'd0, 4'd15, 4'd0},
                              '{4'd7, 4'd0, 4'd15, 4'd15, 4'd0});
    endtask

    // Each new pair must not appear until its own edge.
    task automatic test_stream();
        logic [W-1:0] av[3] = '{4'd5, 4'd1, 4'd6};
        logic [W-1:0] bv[3] = '{4'd4, 4'd8, 4'd6};
        logic [W-1:0] pmin, pmax;
        pmin = o1a;
        pmax = o2a;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            i1 = av[k];
            i2 = bv[k];
            #1;
            checks++;
            if ({o1a, o2a} !== {pmin, pmax}) begin
                errors++;
                $display("FAIL stream_latency k%0d got (%0d,%0d) want (%0d,%0d)", k, o1a, o2a, pmin, pmax);
            end
            @(posedge clk);
            #1;
            pmin = ref_min(av[k], bv[k]);
            pmax = ref_max(av[k], bv[k]);
            checks++;
            if ({o1a, o2a, o1d, o2d} !== {pmin, pmax, pmax, pmin}) begin
                errors++;
                $display("FAIL stream_pair k%0d got asc=(%0d,%0d) dsc=(%0d,%0d) want (%0d,%0d)",
                         k, o1a, o2a, o1d, o2d, pmin, pmax);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] av[$];
        logic [W-1:0] bv[$];
        for (int k = 0; k < 40; k++) begin
            av.push_back(W'($urandom_range(0, (1 << W) - 1)));
            bv.push_back(W'($urandom_range(0, (1 << W) - 1)));
        end
        test_pairs("random", av, bv);
    endtask

    task automatic test_async_reset();
        drive(4'd9, 4'd3);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o1a, o2a, o1d, o2d} !== '0) begin
            errors++;
            $display("FAIL async_reset got asc=(%0d,%0d) dsc=(%0d,%0d) want all 0", o1a, o2a, o1d, o2d);
        end
`ifdef BOTTOM_SORTER_SWAP_FLAG_EN
        checks++;
        if ({swa, swd} !== 2'b00) begin
            errors++;
            $display("FAIL async_reset_swapped got %b%b want 00", swa, swd);
        end
`endif
        drive(4'd2, 4'd1);
        checks++;
        if ({o1a, o2a, o1d, o2d} !== '0) begin
            errors++;
            $display("FAIL reset_hold got asc=(%0d,%0d) dsc=(%0d,%0d) want all 0", o1a, o2a, o1d, o2d);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'd2, 4'd1);
        checks++;
        if ({o1d, o2d} !== {4'd2, 4'd1}) begin
            errors++;
            $display("FAIL descending got (%0d,%0d) want (2,1)", o1d, o2d);
        end
        checks++;
        if ({o1a, o2a} !== {4'd1, 4'd2}) begin
            errors++;
            $display("FAIL post_reset_asc got (%0d,%0d) want (1,2)", o1a, o2a);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ties_extremes();
        test_stream();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
